// File: rtl/uart_pkg.sv
// Shared types, constants and baud-divisor helper for the UART receive path.
// Divisors assume 8x oversampling of each bit.
package uart_pkg;

    localparam int unsigned CLK_HZ_DEFAULT    = 50_000_000;
    localparam int unsigned OVERSAMPLE        = 8;
    localparam int          DATA_BITS_DEFAULT = 8;

    localparam logic [2:0] MID_TICK  = 3'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0] LAST_TICK = 3'(OVERSAMPLE - 1);

    localparam logic [31:0] DIV_2400  = 32'(CLK_HZ_DEFAULT / (OVERSAMPLE * 32'd2400));
    localparam logic [31:0] DIV_4800  = 32'(CLK_HZ_DEFAULT / (OVERSAMPLE * 32'd4800));
    localparam logic [31:0] DIV_9600  = 32'(CLK_HZ_DEFAULT / (OVERSAMPLE * 32'd9600));
    localparam logic [31:0] DIV_19200 = 32'(CLK_HZ_DEFAULT / (OVERSAMPLE * 32'd19200));

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    function automatic logic [31:0] baud_div(input logic [1:0] sel,
                                             input int unsigned clk_hz = CLK_HZ_DEFAULT);
        case (sel)
            2'b00:   baud_div = clk_hz / (OVERSAMPLE * 32'd2400);
            2'b01:   baud_div = clk_hz / (OVERSAMPLE * 32'd4800);
            2'b10:   baud_div = clk_hz / (OVERSAMPLE * 32'd9600);
            default: baud_div = clk_hz / (OVERSAMPLE * 32'd19200);
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// Byte stream from the UART receiver to its consumer (valid/ready handshake).
interface uart_rx_sampler_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DATA_BITS_DEFAULT
);

    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );

endinterface

// File: rtl/uart_rx_tick_gen.sv
// Oversampling tick generator: latches the baud select while idle and
// emits a one-cycle tick every DIV sys_clk cycles.
module uart_rx_tick_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
)
(
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [1:0] sel_baud,
    input  logic       load_sel,
    input  logic       restart,
    output logic       tick
);

    logic [1:0]  sel_q;
    logic [31:0] div_m1;
    logic [31:0] tick_cnt;

    assign div_m1 = baud_div(sel_q, CLK_HZ) - 32'd1;
    assign tick   = !restart && (tick_cnt == div_m1);

    // A frame keeps the rate it started with, even if sel_baud moves mid-frame.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sel_q <= 2'b00;
        end else if (load_sel) begin
            sel_q <= sel_baud;
        end
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            tick_cnt <= '0;
        end else if (restart || tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/uart_rx_sampler.sv
// 8N1 UART receiver, 8x oversampled: synchronizer, framing FSM, shift register
// and a one-deep output register with framing/overrun reporting.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int          DATA_BITS = DATA_BITS_DEFAULT
)
(
    input  logic               sys_clk,
    input  logic               reset,
    input  logic [1:0]         sel_baud,
    input  logic               rxd,
    input  logic               clr_err,
    uart_rx_sampler_if.master  rx_if,
    output logic               frame_err,
    output logic               overrun,
    output logic               busy
);

    localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    logic                 sync_1;
    logic                 rxd_s;
    rx_state_t            state;
    rx_state_t            state_next;
    logic [2:0]           samp_cnt;
    logic [2:0]           samp_cnt_next;
    logic [BIT_W-1:0]     bit_cnt;
    logic [BIT_W-1:0]     bit_cnt_next;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q;
    logic                 shift_en;
    logic                 stop_sample;
    logic                 in_idle;
    logic                 tick;
    logic                 accept;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            sync_1 <= rxd;
            rxd_s  <= sync_1;
        end
    end

    assign in_idle = (state == IDLE);

    uart_rx_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_tick_gen (
        .sys_clk  (sys_clk),
        .reset    (reset),
        .sel_baud (sel_baud),
        .load_sel (in_idle),
        .restart  (in_idle),
        .tick     (tick)
    );

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            samp_cnt <= '0;
            bit_cnt  <= '0;
        end else begin
            state    <= state_next;
            samp_cnt <= samp_cnt_next;
            bit_cnt  <= bit_cnt_next;
        end
    end

    // Start bit is checked mid-bit, after which every 8th tick lands mid-bit.
    always_comb begin
        state_next    = state;
        samp_cnt_next = samp_cnt;
        bit_cnt_next  = bit_cnt;
        shift_en      = 1'b0;
        stop_sample   = 1'b0;
        case (state)
            IDLE: begin
                samp_cnt_next = '0;
                bit_cnt_next  = '0;
                if (!rxd_s) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (samp_cnt == MID_TICK) begin
                        samp_cnt_next = '0;
                        bit_cnt_next  = '0;
                        state_next    = rxd_s ? IDLE : DATA;
                    end else begin
                        samp_cnt_next = samp_cnt + 3'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    samp_cnt_next = samp_cnt + 3'd1;
                    if (samp_cnt == LAST_TICK) begin
                        shift_en     = 1'b1;
                        bit_cnt_next = bit_cnt + 1'b1;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            state_next = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    samp_cnt_next = samp_cnt + 3'd1;
                    if (samp_cnt == LAST_TICK) begin
                        stop_sample = 1'b1;
                        state_next  = rxd_s ? IDLE : BREAK;
                    end
                end
            end
            BREAK: begin
                if (rxd_s) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            shreg <= '0;
        end else if (shift_en) begin
            shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
        end
    end

    assign accept = rx_valid_q && rx_if.rx_ready;

    // A byte accepted in the same cycle frees the slot for the new one;
    // error sets take priority over clr_err.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (stop_sample && (!rx_valid_q || rx_if.rx_ready)) begin
                rx_data_q  <= shreg;
                rx_valid_q <= 1'b1;
            end else if (accept) begin
                rx_valid_q <= 1'b0;
            end

            if (stop_sample && !rxd_s) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end

            if (stop_sample && rx_valid_q && !rx_if.rx_ready) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

    assign rx_if.rx_data  = rx_data_q;
    assign rx_if.rx_valid = rx_valid_q;
    assign busy           = !in_idle;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Bench for uart_rx_sampler: a timing-arithmetic receiver model checked every
// cycle, plus literal expectations for each directed scenario.
module tb_uart_rx_sampler;

    // 1.2288 MHz gives divisors 64/32/16/8, keeping frames short.
    localparam int unsigned TB_CLK_HZ = 1_228_800;

    logic       sys_clk  = 1'b0;
    logic       reset    = 1'b0;
    logic [1:0] sel_baud = 2'b10;
    logic       rxd      = 1'b1;
    logic       clr_err  = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    longint     cyc = 0;
    longint     start_cyc = 0;
    longint     rise_cyc = 0;
    logic [7:0] log_q[$];

    logic [7:0] exp_data  = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;
    logic       exp_busy  = 1'b0;

    uart_rx_sampler_if #(.DATA_BITS(8)) rx_if ();

    uart_rx_sampler #(
        .CLK_HZ    (TB_CLK_HZ),
        .DATA_BITS (8)
    ) dut (
        .sys_clk   (sys_clk),
        .reset     (reset),
        .sel_baud  (sel_baud),
        .rxd       (rxd),
        .clr_err   (clr_err),
        .rx_if     (rx_if),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 sys_clk = ~sys_clk;

    initial forever begin
        @(posedge sys_clk);
        cyc++;
    end

    function automatic int model_div(input logic [1:0] sel);
        return int'(TB_CLK_HZ / (8 * (2400 << sel)));
    endfunction

    // Receiver model: frame time t counts cycles from start detection; bit i is
    // taken at t = 4D + 8D(i+1), the stop bit at t = 76D.
    initial begin
        int         phase;
        int         t;
        int         d;
        logic       h1;
        logic       h2;
        logic       line;
        logic       stop_now;
        logic       pre_valid;
        logic [7:0] bits;
        phase = 0; t = 0; d = 1; h1 = 1'b1; h2 = 1'b1; bits = 8'h00;
        forever begin
            @(posedge sys_clk or negedge reset);
            if (!reset) begin
                phase = 0; t = 0; h1 = 1'b1; h2 = 1'b1; bits = 8'h00;
                exp_data = 8'h00; exp_valid = 1'b0; exp_ferr = 1'b0;
                exp_ovr = 1'b0; exp_busy = 1'b0;
            end else begin
                line      = h2;
                h2        = h1;
                h1        = rxd;
                stop_now  = 1'b0;
                pre_valid = exp_valid;
                case (phase)
                    0: if (!line) begin
                        phase = 1;
                        t     = 0;
                        d     = model_div(sel_baud);
                    end
                    1: begin
                        t++;
                        if (t == 4 * d && line) begin
                            phase = 0;
                        end else if (t > 4 * d && t < 76 * d && (t - 4 * d) % (8 * d) == 0) begin
                            bits[(t - 4 * d) / (8 * d) - 1] = line;
                        end else if (t == 76 * d) begin
                            stop_now = 1'b1;
                            phase    = line ? 0 : 2;
                        end
                    end
                    default: if (line) phase = 0;
                endcase
                if (stop_now && !line) exp_ferr = 1'b1;
                else if (clr_err) exp_ferr = 1'b0;
                if (stop_now && pre_valid && !rx_if.rx_ready) exp_ovr = 1'b1;
                else if (clr_err) exp_ovr = 1'b0;
                if (stop_now && (!pre_valid || rx_if.rx_ready)) begin
                    exp_data  = bits;
                    exp_valid = 1'b1;
                end else if (pre_valid && rx_if.rx_ready) begin
                    exp_valid = 1'b0;
                end
                exp_busy = (phase != 0);
            end
        end
    end

    // Per-cycle comparison against the model, plus a log of accepted bytes.
    initial begin
        logic       prev_valid;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(posedge sys_clk);
            #1;
            if (reset) begin
                if (prev_valid && rx_if.rx_ready) log_q.push_back(prev_data);
                if (rx_if.rx_valid && !prev_valid) rise_cyc = cyc;
                checks++;
                if ({rx_if.rx_valid, rx_if.rx_data, frame_err, overrun, busy} !==
                    {exp_valid, exp_data, exp_ferr, exp_ovr, exp_busy}) begin
                    errors++;
                    $display("[TB] FAIL cycle %0d outputs: got valid=%b data=%h ferr=%b ovr=%b busy=%b, expected valid=%b data=%h ferr=%b ovr=%b busy=%b",
                             cyc, rx_if.rx_valid, rx_if.rx_data, frame_err, overrun, busy,
                             exp_valid, exp_data, exp_ferr, exp_ovr, exp_busy);
                end
            end
            prev_valid = rx_if.rx_valid;
            prev_data  = rx_if.rx_data;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] logged(input int back);
        if (log_q.size() > back) return log_q[log_q.size() - 1 - back];
        return 8'h00;
    endfunction

    // Sends one frame at the currently selected rate; optional clr_err pulse,
    // mid-frame sel_baud change, or reset abort at a given cycle offset.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_val,
                                  input int clr_at, input int sel_at,
                                  input logic [1:0] sel_new, input int abort_at);
        int         d;
        logic [9:0] frame;
        d     = model_div(sel_baud);
        frame = {stop_val, data, 1'b0};
        for (int n = 0; n < 80 * d; n++) begin
            @(negedge sys_clk);
            if (n == abort_at) begin
                reset   = 1'b0;
                rxd     = 1'b1;
                clr_err = 1'b0;
                return;
            end
            if (n == 0) start_cyc = cyc;
            rxd     = frame[n / (8 * d)];
            clr_err = (n == clr_at);
            if (n == sel_at) sel_baud = sel_new;
        end
    endtask

    task automatic pulse_ready();
        @(negedge sys_clk);
        rx_if.rx_ready = 1'b1;
        @(negedge sys_clk);
        rx_if.rx_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge sys_clk);
        clr_err = 1'b1;
        @(negedge sys_clk);
        clr_err = 1'b0;
    endtask

    initial begin
        rx_if.rx_ready = 1'b0;
        repeat (5) @(negedge sys_clk);
        check_output("reset rx_valid", 32'(rx_if.rx_valid), 32'd0);
        check_output("reset rx_data", 32'(rx_if.rx_data), 32'd0);
        check_output("reset frame_err", 32'(frame_err), 32'd0);
        check_output("reset overrun", 32'(overrun), 32'd0);
        check_output("reset busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge sys_clk);

        // Clean 0xA5 at 9600 with the consumer always ready.
        rx_if.rx_ready = 1'b1;
        apply_stimulus(8'hA5, 1'b1, -1, -1, 2'b10, -1);
        repeat (20) @(negedge sys_clk);
        check_output("A5 byte", 32'(logged(0)), 32'h0000_00A5);
        check_output("A5 count", 32'(log_q.size()), 32'd1);
        check_output("A5 latency", 32'(rise_cyc - start_cyc), 32'd1219);
        check_output("A5 valid dropped", 32'(rx_if.rx_valid), 32'd0);
        check_output("A5 frame_err", 32'(frame_err), 32'd0);

        // 40-cycle low glitch, shorter than half a bit.
        @(negedge sys_clk);
        rxd = 1'b0;
        repeat (30) @(negedge sys_clk);
        check_output("glitch busy in start", 32'(busy), 32'd1);
        repeat (10) @(negedge sys_clk);
        rxd = 1'b1;
        repeat (100) @(negedge sys_clk);
        check_output("glitch busy", 32'(busy), 32'd0);
        check_output("glitch no byte", 32'(log_q.size()), 32'd1);
        check_output("glitch frame_err", 32'(frame_err), 32'd0);

        // 0x3C with low stop bit, clr_err colliding with the stop sample, then break.
        rx_if.rx_ready = 1'b0;
        apply_stimulus(8'h3C, 1'b0, 2 + 76 * 16, -1, 2'b10, -1);
        repeat (400) @(negedge sys_clk);
        check_output("break busy", 32'(busy), 32'd1);
        check_output("3C data", 32'(rx_if.rx_data), 32'h0000_003C);
        check_output("3C valid", 32'(rx_if.rx_valid), 32'd1);
        check_output("3C frame_err", 32'(frame_err), 32'd1);
        rxd = 1'b1;
        repeat (10) @(negedge sys_clk);
        check_output("break released", 32'(busy), 32'd0);
        pulse_ready();
        pulse_clr();
        repeat (3) @(negedge sys_clk);
        check_output("frame_err cleared", 32'(frame_err), 32'd0);
        check_output("3C accepted", 32'(logged(0)), 32'h0000_003C);

        // Overrun: 0x11 unread when 0x22 completes.
        apply_stimulus(8'h11, 1'b1, -1, -1, 2'b10, -1);
        apply_stimulus(8'h22, 1'b1, -1, -1, 2'b10, -1);
        repeat (10) @(negedge sys_clk);
        check_output("overrun data kept", 32'(rx_if.rx_data), 32'h0000_0011);
        check_output("overrun set", 32'(overrun), 32'd1);
        pulse_clr();
        repeat (2) @(negedge sys_clk);
        check_output("overrun cleared", 32'(overrun), 32'd0);
        pulse_ready();
        repeat (2) @(negedge sys_clk);
        check_output("11 accepted", 32'(logged(0)), 32'h0000_0011);

        // Reset in the middle of data bit 4 of 0x5A, then a clean 0x5A.
        rx_if.rx_ready = 1'b1;
        apply_stimulus(8'h5A, 1'b1, -1, -1, 2'b10, 44 * 16);
        repeat (3) @(negedge sys_clk);
        check_output("abort rx_data", 32'(rx_if.rx_data), 32'd0);
        check_output("abort rx_valid", 32'(rx_if.rx_valid), 32'd0);
        check_output("abort busy", 32'(busy), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge sys_clk);
        apply_stimulus(8'h5A, 1'b1, -1, -1, 2'b10, -1);
        repeat (20) @(negedge sys_clk);
        check_output("5A after reset", 32'(logged(0)), 32'h0000_005A);

        // 19200 back-to-back; sel_baud moves to 9600 during the second frame.
        sel_baud = 2'b11;
        repeat (5) @(negedge sys_clk);
        apply_stimulus(8'h00, 1'b1, -1, -1, 2'b11, -1);
        apply_stimulus(8'hFF, 1'b1, -1, 3 * 64, 2'b10, -1);
        repeat (20) @(negedge sys_clk);
        check_output("b2b first", 32'(logged(1)), 32'h0000_0000);
        check_output("b2b second", 32'(logged(0)), 32'h0000_00FF);
        check_output("b2b flags", 32'({frame_err, overrun}), 32'd0);
        apply_stimulus(8'hC3, 1'b1, -1, -1, 2'b10, -1);
        repeat (20) @(negedge sys_clk);
        check_output("new rate byte", 32'(logged(0)), 32'h0000_00C3);
        check_output("new rate latency", 32'(rise_cyc - start_cyc), 32'd1219);
        check_output("total bytes", 32'(log_q.size()), 32'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
